// File: rtl/sp_render_pkg.sv
// Shared types and constants for the sprite pixel stage: secondary OAM entry layout,
// slot output bundle, timing constants and attribute bit positions.
package sp_render_pkg;

  localparam int unsigned SP_LOAD_START = 321;
  localparam int unsigned VISIBLE_ROWS  = 240;
  localparam int unsigned VISIBLE_COLS  = 256;

  localparam int unsigned ATTR_PRIO   = 5;
  localparam int unsigned ATTR_FLIP_H = 6;
  localparam int unsigned ATTR_FLIP_V = 7;

  typedef struct packed {
    logic       active;
    logic [7:0] x_pos;
    logic [7:0] attribute;
    logic [7:0] bitmap_lo;
    logic [7:0] bitmap_hi;
  } second_oam_t;

  typedef struct packed {
    logic [1:0] px;
    logic [1:0] pal;
    logic       prio;
  } slot_out_t;

  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sp_slot.sv
// One sprite slot: X down-counter, two pattern shifters and latched palette/priority.
// The slot reports a pixel only while its counter has reached zero.
module sp_slot
  import sp_render_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_shift,
  input  second_oam_t i_data,
  output slot_out_t   o_slot
);

  logic [7:0] r_x_cnt;
  logic [7:0] r_lo;
  logic [7:0] r_hi;
  logic [1:0] r_pal;
  logic       r_prio;

  logic       w_live;
  logic [7:0] w_lo_in;
  logic [7:0] w_hi_in;
  logic       w_unused_attr;

  assign w_live  = (r_x_cnt == 8'd0);
  assign w_lo_in = i_data.attribute[ATTR_FLIP_H] ? bit_rev(i_data.bitmap_lo) : i_data.bitmap_lo;
  assign w_hi_in = i_data.attribute[ATTR_FLIP_H] ? bit_rev(i_data.bitmap_hi) : i_data.bitmap_hi;

  // Vertical flip is resolved upstream when the pattern row is fetched.
  assign w_unused_attr = ^{i_data.attribute[ATTR_FLIP_V], i_data.attribute[4:2]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x_cnt <= 8'd0;
      r_lo    <= 8'd0;
      r_hi    <= 8'd0;
      r_pal   <= 2'd0;
      r_prio  <= 1'b0;
    end else if (i_load) begin
      r_pal  <= i_data.attribute[1:0];
      r_prio <= i_data.attribute[ATTR_PRIO];
      if (i_data.active) begin
        r_x_cnt <= i_data.x_pos;
        r_lo    <= w_lo_in;
        r_hi    <= w_hi_in;
      end else begin
        r_x_cnt <= 8'd0;
        r_lo    <= 8'd0;
        r_hi    <= 8'd0;
      end
    end else if (i_shift) begin
      if (w_live) begin
        r_lo <= {r_lo[6:0], 1'b0};
        r_hi <= {r_hi[6:0], 1'b0};
      end else begin
        r_x_cnt <= r_x_cnt - 8'd1;
      end
    end
  end

  assign o_slot.px   = w_live ? {r_hi[7], r_lo[7]} : 2'b00;
  assign o_slot.pal  = r_pal;
  assign o_slot.prio = r_prio;

endmodule

// File: rtl/sp_render.sv
// Sprite pixel stage: loads secondary OAM into slots at the end of each line and
// emits one registered, prioritised sprite pixel per visible PPU clock.
module sp_render
  import sp_render_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [8:0]  row,
  input  logic [8:0]  col,
  input  logic        sp_en,
  input  logic        sp_left_en,
  input  logic        sp0_on_line,
  output logic [2:0]  sec_oam_rd_idx,
  input  second_oam_t sec_oam_rd_data,
  output logic [3:0]  sp_pixel,
  output logic        sp_behind_bg,
  output logic        sp_zero_px
);

  logic [8:0] w_col_off;
  logic       w_load_win;
  logic       w_visible;
  logic       w_left_clip;
  logic       w_shift;

  logic       w_found;
  logic       w_win_zero;
  slot_out_t  w_win;
  slot_out_t  w_slot [NUM_SLOTS];

  logic       r_z_flag;
  logic [3:0] r_sp_pixel;
  logic       r_sp_behind_bg;
  logic       r_sp_zero_px;

  // Columns below the window wrap to large offsets, so one compare covers both bounds.
  assign w_col_off      = col - 9'(SP_LOAD_START);
  assign w_load_win     = (w_col_off < 9'(NUM_SLOTS));
  assign sec_oam_rd_idx = (w_load_win && !rst) ? w_col_off[2:0] : 3'd0;

  assign w_visible   = (row < 9'(VISIBLE_ROWS)) && (col != 9'd0) && (col <= 9'(VISIBLE_COLS));
  assign w_left_clip = (col <= 9'd8) && !sp_left_en;
  assign w_shift     = clk_en && w_visible;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sp_slot u_slot (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (clk_en && w_load_win && (w_col_off[2:0] == 3'(g))),
      .i_shift (w_shift),
      .i_data  (sec_oam_rd_data),
      .o_slot  (w_slot[g])
    );
  end

  always_comb begin
    w_found    = 1'b0;
    w_win_zero = 1'b0;
    w_win      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_found && (w_slot[i].px != 2'b00)) begin
        w_found    = 1'b1;
        w_win      = w_slot[i];
        w_win_zero = (i == 0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z_flag       <= 1'b0;
      r_sp_pixel     <= 4'd0;
      r_sp_behind_bg <= 1'b0;
      r_sp_zero_px   <= 1'b0;
    end else if (clk_en) begin
      if (w_load_win && (w_col_off[2:0] == 3'd0)) begin
        r_z_flag <= sp0_on_line;
      end
      if (w_visible && sp_en && !w_left_clip && w_found) begin
        r_sp_pixel     <= {w_win.pal, w_win.px};
        r_sp_behind_bg <= w_win.prio;
        r_sp_zero_px   <= w_win_zero && r_z_flag;
      end else begin
        r_sp_pixel     <= 4'd0;
        r_sp_behind_bg <= 1'b0;
        r_sp_zero_px   <= 1'b0;
      end
    end
  end

  assign sp_pixel     = r_sp_pixel;
  assign sp_behind_bg = r_sp_behind_bg;
  assign sp_zero_px   = r_sp_zero_px;

endmodule

// File: tb/tb_sp_render.sv
// Scoreboard bench for sp_render: the driver walks scanlines and pushes expected pixels
// from a screen-coordinate sprite model; a monitor compares on every clk_en edge.
module tb_sp_render;
  import sp_render_pkg::*;

  localparam int NS        = 20;
  localparam int RST_SCENE = 10;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [8:0]  row;
  logic [8:0]  col;
  logic        sp_en;
  logic        sp_left_en;
  logic        sp0_on_line;
  logic [2:0]  sec_oam_rd_idx;
  second_oam_t sec_oam_rd_data;
  logic [3:0]  sp_pixel;
  logic        sp_behind_bg;
  logic        sp_zero_px;

  sp_render #(.NUM_SLOTS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .clk_en          (clk_en),
    .row             (row),
    .col             (col),
    .sp_en           (sp_en),
    .sp_left_en      (sp_left_en),
    .sp0_on_line     (sp0_on_line),
    .sec_oam_rd_idx  (sec_oam_rd_idx),
    .sec_oam_rd_data (sec_oam_rd_data),
    .sp_pixel        (sp_pixel),
    .sp_behind_bg    (sp_behind_bg),
    .sp_zero_px      (sp_zero_px)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Secondary OAM memory, read combinationally at the DUT's index.
  second_oam_t tb_oam [8];
  assign sec_oam_rd_data = tb_oam[sec_oam_rd_idx];

  // Scenes: OAM contents loaded at the end of one line, shown on the next.
  second_oam_t scn_oam  [NS][8];
  bit          scn_sp0  [NS];
  bit          scn_en   [NS];
  bit          scn_left [NS];
  int          scn_row  [NS];

  // Reference model: what each slot was loaded with on the last load window.
  second_oam_t m_spr [8];
  bit          m_z;

  typedef struct {
    logic [5:0] v;
    int         r;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  exp_t       e;
  logic       mon_en;
  logic [5:0] last_v;
  bit         have_last = 0;

  // Expected {pixel, behind, zero} for the enabled cycle at column c.
  function automatic logic [5:0] model_px(input int c, input bit r);
    int x;
    int xp;
    int j;
    int b;
    logic [1:0] p;
    if (r) return 6'd0;
    if (!(int'(row) < 240 && c >= 1 && c <= 256)) return 6'd0;
    if (!sp_en) return 6'd0;
    if (c <= 8 && !sp_left_en) return 6'd0;
    x = c - 1;
    for (int i = 0; i < 8; i++) begin
      xp = int'(m_spr[i].x_pos);
      if (m_spr[i].active && x >= xp && x < xp + 8) begin
        j = x - xp;
        b = m_spr[i].attribute[6] ? j : 7 - j;
        p = {m_spr[i].bitmap_hi[b], m_spr[i].bitmap_lo[b]};
        if (p != 2'b00) begin
          return {m_spr[i].attribute[1:0], p, m_spr[i].attribute[5], (i == 0) && m_z};
        end
      end
    end
    return 6'd0;
  endfunction

  task automatic tick(input int c, input bit r);
    int idle;
    int exp_idx;
    exp_t ex;
    idle   = $urandom_range(0, 2);
    col    = 9'(c);
    rst    = 1'b0;
    clk_en = 1'b0;
    #1;
    exp_idx = (c >= 321 && c <= 328) ? c - 321 : 0;
    checks++;
    if (int'(sec_oam_rd_idx) != exp_idx) begin
      errors++;
      $display("FAIL rd_idx row=%0d col=%0d got=%0d exp=%0d", row, c, sec_oam_rd_idx, exp_idx);
    end
    repeat (idle) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst    = r;
    clk_en = 1'b1;
    ex.v = model_px(c, r);
    ex.r = int'(row);
    ex.c = c;
    exp_q.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    clk_en = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_spr[i] = '0;
      m_z = 1'b0;
    end else if (c >= 321 && c <= 328) begin
      m_spr[c-321] = tb_oam[c-321];
      if (c == 321) m_z = sp0_on_line;
    end
  endtask

  always @(posedge clk) begin
    mon_en = clk_en;
    #1;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got=%h", {sp_pixel, sp_behind_bg, sp_zero_px});
      end else begin
        e = exp_q.pop_front();
        if ({sp_pixel, sp_behind_bg, sp_zero_px} !== e.v) begin
          errors++;
          $display("FAIL pixel row=%0d col=%0d got px=%h bg=%b z=%b exp px=%h bg=%b z=%b",
                   e.r, e.c, sp_pixel, sp_behind_bg, sp_zero_px, e.v[5:2], e.v[1], e.v[0]);
        end
        last_v    = e.v;
        have_last = 1;
      end
    end else if (have_last) begin
      checks++;
      if ({sp_pixel, sp_behind_bg, sp_zero_px} !== last_v) begin
        errors++;
        $display("FAIL hold got=%h exp=%h", {sp_pixel, sp_behind_bg, sp_zero_px}, last_v);
      end
    end
  end

  task automatic set_spr(input int s, input int i, input int x, input logic [7:0] lo,
                         input logic [7:0] hi, input logic [7:0] attr, input bit act);
    scn_oam[s][i].active    = act;
    scn_oam[s][i].x_pos     = 8'(x);
    scn_oam[s][i].attribute = attr;
    scn_oam[s][i].bitmap_lo = lo;
    scn_oam[s][i].bitmap_hi = hi;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 8; i++) scn_oam[s][i] = '0;
      scn_sp0[s]  = 1'b0;
      scn_en[s]   = 1'b1;
      scn_left[s] = 1'b1;
      scn_row[s]  = s + 1;
    end
    set_spr(0, 0, 10, 8'hF0, 8'h00, 8'h02, 1);
    set_spr(1, 0, 10, 8'hF0, 8'h00, 8'h42, 1);
    set_spr(2, 1, 20, 8'hFF, 8'hFF, 8'h21, 1);
    set_spr(2, 3, 20, 8'hFF, 8'hFF, 8'h03, 1);
    set_spr(3, 1, 20, 8'h00, 8'h00, 8'h21, 1);
    set_spr(3, 3, 20, 8'hFF, 8'hFF, 8'h03, 1);
    set_spr(4, 0, 0, 8'hFF, 8'h00, 8'h00, 1);
    scn_left[4] = 1'b0;
    set_spr(5, 0, 0, 8'hFF, 8'h00, 8'h00, 1);
    set_spr(6, 0, 50, 8'hFF, 8'h00, 8'h00, 1);
    scn_sp0[6] = 1'b1;
    set_spr(7, 0, 50, 8'hFF, 8'h00, 8'h00, 1);
    set_spr(8, 0, 5, 8'hFF, 8'hFF, 8'h03, 0);
    set_spr(8, 2, 255, 8'hFF, 8'hFF, 8'h03, 1);
    set_spr(8, 4, 0, 8'hFF, 8'hFF, 8'h01, 0);
    set_spr(8, 5, 200, 8'h00, 8'h00, 8'h02, 1);
    set_spr(9, 0, 30, 8'hFF, 8'h00, 8'h00, 1);
    scn_en[9] = 1'b0;
    set_spr(10, 0, 95, 8'hFF, 8'hAA, 8'h01, 1);
    set_spr(10, 1, 150, 8'hFF, 8'h00, 8'h02, 1);
    scn_sp0[10] = 1'b1;
    set_spr(11, 0, 5, 8'hFF, 8'h00, 8'h00, 1);
    scn_row[11] = 245;
    for (int s = 12; s < NS; s++) begin
      for (int i = 0; i < 8; i++) begin
        set_spr(s, i, $urandom_range(0, 255), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3) != 0);
      end
      scn_sp0[s]  = 1'($urandom);
      scn_en[s]   = $urandom_range(0, 4) != 0;
      scn_left[s] = 1'($urandom);
      scn_row[s]  = ($urandom_range(0, 5) == 0) ? $urandom_range(240, 261)
                                                : $urandom_range(0, 239);
    end

    for (int i = 0; i < 8; i++) begin
      tb_oam[i] = '0;
      m_spr[i]  = '0;
    end
    m_z         = 1'b0;
    rst         = 1'b0;
    clk_en      = 1'b0;
    row         = 9'd0;
    col         = 9'd0;
    sp_en       = 1'b1;
    sp_left_en  = 1'b1;
    sp0_on_line = 1'b0;

    for (int k = 0; k < 3; k++) tick(0, 1'b1);

    for (int it = 0; it <= NS; it++) begin
      row        = (it == 0) ? 9'd0 : 9'(scn_row[it-1]);
      sp_en      = (it == 0) ? 1'b1 : scn_en[it-1];
      sp_left_en = (it == 0) ? 1'b1 : scn_left[it-1];
      for (int c = 0; c <= 340; c++) begin
        if (c == 300 && it < NS) begin
          for (int i = 0; i < 8; i++) tb_oam[i] = scn_oam[it][i];
          sp0_on_line = scn_sp0[it];
        end
        tick(c, (it - 1 == RST_SCENE) && (c == 100));
      end
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
